// File: rtl/fp_normalizer_pipe_if.sv
// Handshake bundle for fp_normalizer_pipe.
// Input beat and output result share one interface.
interface fp_normalizer_pipe_if #(
  parameter int EXP_W = 8,
  parameter int IN_W  = 22,
  parameter int OUT_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] in_ex;
  logic [IN_W-1:0]  in_sig;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] out_ex;
  logic [OUT_W-1:0] out_sig;
  logic             out_zero;
  logic             out_ovf;
  logic             out_unf;

  modport master (
    output in_valid, in_ex, in_sig, out_ready,
    input  in_ready, out_valid, out_ex, out_sig,
    input  out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_ex, in_sig, out_ready,
    output in_ready, out_valid, out_ex, out_sig,
    output out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_normalizer_pipe.sv
// Two-stage significand normalizer: leading-one detect,
// left-justify, exponent adjust, optional RNE, flags.
module fp_normalizer_pipe #(
  parameter int EXP_W    = 8,
  parameter int IN_W     = 22,
  parameter int OUT_W    = 24,
  parameter int BIAS_ADJ = 20,
  parameter int ROUND_EN = 1
) (
  input logic clock,
  input logic resetn,
  fp_normalizer_pipe_if.slave bus
);
  localparam int PW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX =
    EW'((1 << EXP_W) - 1);

  logic             s1_valid;
  logic [EXP_W-1:0] s1_ex;
  logic [IN_W-1:0]  s1_sig;
  logic [PW-1:0]    s1_pos;
  logic             s1_zero;

  logic s1_adv;
  logic s2_adv;
  logic [PW-1:0] pos;

  assign s2_adv = !bus.out_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  always_comb begin
    pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (bus.in_sig[i]) pos = PW'(i);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_ex    <= '0;
      s1_sig   <= '0;
      s1_pos   <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ex   <= bus.in_ex;
        s1_sig  <= bus.in_sig;
        s1_pos  <= pos;
        s1_zero <= ~|bus.in_sig;
      end
    end
  end

  logic [IN_W-1:0]         n;
  logic signed [EW-1:0]    e_raw;
  logic signed [EW-1:0]    e_fin;
  logic [OUT_W-1:0]        frac;
  logic                    carry;

  assign n = s1_sig << (PW'(IN_W - 1) - s1_pos);
  assign e_raw = $signed({2'b00, s1_ex})
               + $signed(EW'(s1_pos))
               - $signed(EW'(BIAS_ADJ));
  assign e_fin = e_raw
               + $signed({{(EW-1){1'b0}}, carry});

  generate
    if (OUT_W >= IN_W) begin : g_pad
      assign frac  = OUT_W'(n) << (OUT_W - IN_W);
      assign carry = 1'b0;
    end else begin : g_rnd
      localparam int RW = IN_W - OUT_W;
      logic [OUT_W-1:0] top;
      logic [RW-1:0]    rest;
      logic [RW-1:0]    low;
      logic             guard;
      logic             sticky;
      logic             up;
      logic [OUT_W:0]   sum;

      assign top    = n[IN_W-1 -: OUT_W];
      assign rest   = n[RW-1:0];
      // Dropping the guard bit leaves only sticky bits.
      assign low    = rest << 1;
      assign guard  = rest[RW-1];
      assign sticky = |low;
      assign up     = (ROUND_EN != 0) && guard
                    && (sticky || top[0]);
      assign sum    = {1'b0, top} + (OUT_W+1)'(up);
      assign carry  = sum[OUT_W];
      assign frac   = carry
                    ? (OUT_W'(1) << (OUT_W - 1))
                    : sum[OUT_W-1:0];
    end
  endgenerate

  logic [EXP_W-1:0] nx_ex;
  logic [OUT_W-1:0] nx_sig;
  logic             nx_zero;
  logic             nx_ovf;
  logic             nx_unf;

  always_comb begin
    nx_ex   = e_fin[EXP_W-1:0];
    nx_sig  = frac;
    nx_zero = 1'b0;
    nx_ovf  = 1'b0;
    nx_unf  = 1'b0;
    if (s1_zero) begin
      nx_ex   = '0;
      nx_sig  = '0;
      nx_zero = 1'b1;
    end else if (e_fin <= 0) begin
      nx_ex  = '0;
      nx_sig = '0;
      nx_unf = 1'b1;
    end else if (e_fin >= EMAX) begin
      nx_ex  = '1;
      nx_sig = '0;
      nx_ovf = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.out_valid <= 1'b0;
      bus.out_ex    <= '0;
      bus.out_sig   <= '0;
      bus.out_zero  <= 1'b0;
      bus.out_ovf   <= 1'b0;
      bus.out_unf   <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_ex   <= nx_ex;
        bus.out_sig  <= nx_sig;
        bus.out_zero <= nx_zero;
        bus.out_ovf  <= nx_ovf;
        bus.out_unf  <= nx_unf;
      end
    end
  end
endmodule
